packet_encode_fsm_tx: RTL and testbench

PACKET_ENCODE_FSM_TX -- requirements
Module: packet_encode_fsm_tx

---
 rtl/packet_encode_fsm_tx.sv | 144 ++++++++++++++
 tb/tb_packet_encode_fsm_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_encode_fsm_tx.sv
// packet_encode_fsm_tx
// Frames one packet for a UART word transmitter: optional resync word, SOP
// header, then i_len payload words pulled from an upstream valid/ready source.
// Optional feature macro: PACKET_ENCODE_RESYNC_EN (adds the resync word
// 32'h416FDC1E ahead of every header).
//
// Handshake semantics (both sides): a word moves on a rising edge only when
// valid and ready are both high on that cycle; a valid word and its data are
// held unchanged until that happens. Payload ready is independent of payload
// valid.
module packet_encode_fsm_tx #(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_payload_valid,
  input  logic [31:0]      i_payload_data,
  output logic             o_payload_ready,
  output logic             o_tx_valid,
  output logic [31:0]      o_tx_data,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_collision,
  output logic [2:0]       o_state
);

  localparam logic [31:0] RESYNC_WORD = 32'h416F_DC1E;
  localparam logic [31:0] SOP_WORD    = 32'hD78C_1B74;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESYNC = 3'd1,
    ST_SOP    = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic             tx_xfer;
  logic             pay_xfer;

  // Payload is pulled while the output register is empty or draining; SOP is
  // included so the first payload word follows the header with no bubble.
  always_comb begin
    o_payload_ready = 1'b0;
    if (!i_abort && (state == ST_SOP || state == ST_DATA) && count != '0)
      o_payload_ready = !o_tx_valid || i_tx_ready;
  end

  // Handshake strobes and state visibility.
  always_comb begin
    tx_xfer  = o_tx_valid && i_tx_ready;
    pay_xfer = i_payload_valid && o_payload_ready;
    o_busy   = (state != ST_IDLE);
    o_state  = state;
  end

  // Packet framing FSM with registered transmit outputs and pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= '0;
      o_done      <= 1'b0;
      o_collision <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_collision <= 1'b0;
      if (state != ST_IDLE && i_abort) begin
        // Abandon everything, including an untransferred word.
        state      <= ST_IDLE;
        count      <= '0;
        o_tx_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              count      <= i_len;
              o_tx_valid <= 1'b1;
`ifdef PACKET_ENCODE_RESYNC_EN
              o_tx_data  <= RESYNC_WORD;
              state      <= ST_RESYNC;
`else
              o_tx_data  <= SOP_WORD;
              state      <= ST_SOP;
`endif
            end
          end
          ST_RESYNC: begin
            if (tx_xfer) begin
              o_tx_data <= SOP_WORD;
              state     <= ST_SOP;
            end
          end
          ST_SOP: begin
            if (tx_xfer) begin
              if (pay_xfer) begin
                o_tx_data   <= i_payload_data;
                count       <= count - 1'b1;
                o_collision <= (i_payload_data == RESYNC_WORD);
                state       <= ST_DATA;
              end else if (count != '0) begin
                o_tx_valid <= 1'b0;
                state      <= ST_DATA;
              end else begin
                o_tx_valid <= 1'b0;
                o_done     <= 1'b1;
                state      <= ST_DONE;
              end
            end
          end
          ST_DATA: begin
            if (pay_xfer) begin
              o_tx_valid  <= 1'b1;
              o_tx_data   <= i_payload_data;
              count       <= count - 1'b1;
              o_collision <= (i_payload_data == RESYNC_WORD);
            end else if (tx_xfer) begin
              o_tx_valid <= 1'b0;
              if (count == '0) begin
                o_done <= 1'b1;
                state  <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state      <= ST_IDLE;
            o_tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_encode_fsm_tx.sv
// Testbench for packet_encode_fsm_tx (directed vectors, scoreboard queues).
module tb_packet_encode_fsm_tx;

  localparam int          LEN_W    = 16;
  localparam logic [31:0] W_RESYNC = 32'h416F_DC1E;
  localparam logic [31:0] W_SOP    = 32'hD78C_1B74;
`ifdef PACKET_ENCODE_RESYNC_EN
  localparam int NH = 2;
`else
  localparam int NH = 1;
`endif

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_start = 1'b0;
  logic [LEN_W-1:0] i_len = '0;
  logic             i_abort = 1'b0;
  logic             i_payload_valid = 1'b0;
  logic [31:0]      i_payload_data = '0;
  logic             o_payload_ready;
  logic             o_tx_valid;
  logic [31:0]      o_tx_data;
  logic             i_tx_ready = 1'b1;
  logic             o_busy, o_done, o_collision;
  logic [2:0]       o_state;

  always #5 clk = ~clk;

  packet_encode_fsm_tx #(.LEN_W(LEN_W)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
    .i_abort(i_abort), .i_payload_valid(i_payload_valid),
    .i_payload_data(i_payload_data), .o_payload_ready(o_payload_ready),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_collision(o_collision),
    .o_state(o_state)
  );

  // Narrow instance for the all-ones length boundary.
  logic        s_start = 1'b0;
  logic [2:0]  s_len = '0;
  logic [31:0] s_data = '0;
  logic        s_pready, s_tvalid, s_busy, s_done, s_coll;
  logic [31:0] s_tdata;
  logic [2:0]  s_state;
  int          s_acc = 0, s_xfer = 0, s_done_cnt = 0;

  packet_encode_fsm_tx #(.LEN_W(3)) u_dut3 (
    .i_clk(clk), .i_reset(i_reset), .i_start(s_start), .i_len(s_len),
    .i_abort(1'b0), .i_payload_valid(1'b1), .i_payload_data(s_data),
    .o_payload_ready(s_pready), .o_tx_valid(s_tvalid), .o_tx_data(s_tdata),
    .i_tx_ready(1'b1), .o_busy(s_busy), .o_done(s_done),
    .o_collision(s_coll), .o_state(s_state)
  );

  always @(posedge clk) begin
    if (s_pready) begin s_acc++; s_data <= s_data + 1; end
    if (s_tvalid) s_xfer++;
    if (s_done) s_done_cnt++;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] pay_src[$];
  int  cyc = 0, done_cnt = 0, done_cyc = 0, coll_cnt = 0, coll_cyc = 0;
  int  pay_acc = 0, rdy_cnt = 0, hold_viol = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;
  bit  pay_en = 1'b0, tog_en = 1'b0;
  int  n_chk = 0, n_fail = 0;

  always @(posedge clk) begin
    if (o_tx_valid && i_tx_ready) begin got_q.push_back(o_tx_data); got_cyc.push_back(cyc); end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_collision) begin coll_cnt++; coll_cyc = cyc; end
    if (i_payload_valid && o_payload_ready) pay_acc++;
    if (o_payload_ready) rdy_cnt++;
    if (hold_pend && !(o_tx_valid && o_tx_data == hold_data)) hold_viol++;
    hold_pend = o_tx_valid && !i_tx_ready && !i_abort && !i_reset;
    hold_data = o_tx_data;
    cyc++;
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (i_payload_valid && o_payload_ready && pay_src.size() > 0) tmp = pay_src.pop_front();
    #2;
    if (pay_en && pay_src.size() > 0) begin
      i_payload_valid = 1'b1;
      i_payload_data  = pay_src[0];
    end else begin
      i_payload_valid = 1'b0;
      i_payload_data  = '0;
    end
    if (tog_en) i_tx_ready = !i_tx_ready;
  end

  function automatic logic [31:0] hdr_word(input int i);
    if (NH == 2 && i == 0) return W_RESYNC;
    return W_SOP;
  endfunction

  task automatic clear_mon();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    done_cnt = 0; coll_cnt = 0; pay_acc = 0; rdy_cnt = 0; hold_viol = 0;
    hold_pend = 1'b0;
    for (int i = 0; i < NH; i++) exp_q.push_back(hdr_word(i));
  endtask

  task automatic start_pkt(input logic [LEN_W-1:0] len);
    i_start = 1'b1; i_len = len;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_cnt != 0) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", o_tx_valid); end
    n_chk++; if (o_tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", o_tx_data); end
    n_chk++; if (o_payload_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b expected 0", o_payload_ready); end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_chk++; if (o_done !== 1'b0 || o_collision !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b coll=%b expected 0 0", o_done, o_collision); end
    n_chk++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    i_reset = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    pay_src = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    foreach (pay_src[i]) exp_q.push_back(pay_src[i]);
    pay_en = 1'b1;
    start_pkt(3);
    wait_done(50, to);
    pay_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      n_chk++; if (got_cyc[i] != got_cyc[0] + i) begin n_fail++; $display("FAIL basic_gap[%0d]: got cycle %0d expected %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
    if (got_q.size() > 0) begin
      n_chk++; if (done_cyc != got_cyc[got_cyc.size()-1] + 1) begin n_fail++; $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, got_cyc[got_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clear_mon();
    pay_src = '{32'hDEAD_0001};
    pay_en = 1'b1;
    start_pkt(0);
    wait_done(30, to);
    pay_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL zero_timeout: got no done expected done"); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (rdy_cnt != 0) begin n_fail++; $display("FAIL zero_pready: got %0d ready cycles expected 0", rdy_cnt); end
    if (got_q.size() > 0) begin
      n_chk++; if (done_cyc != got_cyc[got_cyc.size()-1] + 1) begin n_fail++; $display("FAIL zero_done_time: got %0d expected %0d", done_cyc, got_cyc[got_cyc.size()-1] + 1); end
    end
    pay_src.delete();
  endtask

  task automatic test_toggle_ready();
    bit to;
    clear_mon();
    pay_src = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
    foreach (pay_src[i]) exp_q.push_back(pay_src[i]);
    pay_en = 1'b1;
    i_tx_ready = 1'b1;
    tog_en = 1'b1;
    start_pkt(4);
    wait_done(80, to);
    tog_en = 1'b0; pay_en = 1'b0;
    #3 i_tx_ready = 1'b1;
    n_chk++; if (to) begin n_fail++; $display("FAIL toggle_timeout: got no done expected done"); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (pay_acc != 4) begin n_fail++; $display("FAIL toggle_accepts: got %0d expected 4", pay_acc); end
    n_chk++; if (hold_viol != 0) begin n_fail++; $display("FAIL toggle_hold: got %0d violations expected 0", hold_viol); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL toggle_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_collision();
    bit to;
    clear_mon();
    pay_src = '{W_RESYNC, 32'h0000_1234};
    foreach (pay_src[i]) exp_q.push_back(pay_src[i]);
    pay_en = 1'b1;
    start_pkt(2);
    wait_done(40, to);
    pay_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL coll_timeout: got no done expected done"); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL coll_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL coll_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (coll_cnt != 1) begin n_fail++; $display("FAIL coll_pulses: got %0d expected 1", coll_cnt); end
    if (got_cyc.size() > NH) begin
      n_chk++; if (coll_cyc != got_cyc[NH]) begin n_fail++; $display("FAIL coll_time: got %0d expected %0d", coll_cyc, got_cyc[NH]); end
    end
  endtask

  task automatic test_abort();
    bit to;
    clear_mon();
    pay_src = '{32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004, 32'h5000_0005};
    pay_en = 1'b1;
    start_pkt(5);
    to = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (pay_acc >= 2) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (to) begin n_fail++; $display("FAIL abort_reach: got %0d accepts expected 2", pay_acc); end
    i_abort = 1'b1; pay_en = 1'b0;
    @(posedge clk); #1;
    i_abort = 1'b0;
    pay_src.delete();
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
    n_chk++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_tx_valid: got %b expected 0", o_tx_valid); end
    n_chk++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", o_state); end
    repeat (3) begin @(posedge clk); #1; end
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    n_chk++; if (pay_acc != 2) begin n_fail++; $display("FAIL abort_accepts: got %0d expected 2", pay_acc); end
    // A fresh packet after the abort is complete.
    clear_mon();
    pay_src = '{32'h0000_0055};
    exp_q.push_back(32'h0000_0055);
    pay_en = 1'b1;
    start_pkt(1);
    wait_done(30, to);
    pay_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL abort_next_timeout: got no done expected done"); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_next_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_mon();
    pay_src = '{32'h6000_0001, 32'h6000_0002};
    foreach (pay_src[i]) exp_q.push_back(pay_src[i]);
    pay_en = 1'b1;
    start_pkt(2);
    i_start = 1'b1; i_len = 16'd9;
    repeat (2) begin @(posedge clk); #1; end
    i_start = 1'b0; i_len = '0;
    wait_done(40, to);
    pay_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: got no done expected done"); end
    n_chk++; if (pay_acc != 2) begin n_fail++; $display("FAIL busy_start_accepts: got %0d expected 2", pay_acc); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_start_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_mon();
    pay_src = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004};
    pay_en = 1'b1;
    start_pkt(4);
    to = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (pay_acc >= 1) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (to) begin n_fail++; $display("FAIL rstmid_reach: got %0d accepts expected 1", pay_acc); end
    i_reset = 1'b1; i_start = 1'b1; i_len = 16'd3;
    #1;
    n_chk++; if (o_tx_valid !== 1'b0 || o_tx_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_tx: got valid=%b data=%h expected 0 0", o_tx_valid, o_tx_data); end
    n_chk++; if (o_busy !== 1'b0 || o_payload_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got busy=%b ready=%b expected 0 0", o_busy, o_payload_ready); end
    n_chk++; if (o_done !== 1'b0 || o_collision !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got done=%b coll=%b expected 0 0", o_done, o_collision); end
    @(posedge clk); #1;
    n_chk++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", o_state); end
    i_start = 1'b0; i_len = '0; pay_en = 1'b0;
    pay_src.delete();
    i_reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_busy: got %b expected 0", o_busy); end
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_max_len();
    bit to;
    s_acc = 0; s_xfer = 0; s_done_cnt = 0;
    s_start = 1'b1; s_len = 3'd7;
    @(posedge clk); #1;
    s_start = 1'b0; s_len = '0;
    to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (s_done_cnt != 0) begin to = 1'b0; break; end
    end
    repeat (2) begin @(posedge clk); #1; end
    n_chk++; if (to) begin n_fail++; $display("FAIL maxlen_timeout: got no done expected done"); end
    n_chk++; if (s_acc != 7) begin n_fail++; $display("FAIL maxlen_accepts: got %0d expected 7", s_acc); end
    n_chk++; if (s_xfer != NH + 7) begin n_fail++; $display("FAIL maxlen_words: got %0d expected %0d", s_xfer, NH + 7); end
    n_chk++; if (s_done_cnt != 1) begin n_fail++; $display("FAIL maxlen_done: got %0d expected 1", s_done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_toggle_ready();
    test_collision();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
